// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bring-up controller: opcodes, the
// expected chip ID and the controller state encoding.
package spi_pkg;

  localparam logic [7:0] CHIPID_REG = 8'h00;
  localparam logic [7:0] DBG8_REG   = 8'hB8;
  localparam logic [7:0] DBG32_REG  = 8'hB9;
  localparam logic [7:0] DBG_RAM16  = 8'hBA;
  localparam logic [7:0] DBG_RAM32  = 8'hBB;

  localparam logic [7:0] CHIPID     = 8'hAA;

  // Smallest legal SCK half-period: the peripheral needs 3 clk cycles
  // after an SCK fall before CIPO is valid.
  localparam int MIN_CLK_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_HOLD = 3'd3,
    ST_GAP  = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: a CLK_DIV-cycle divider that toggles sck while enabled and
// reports the upcoming rising/falling sck edge as single-cycle pulses, so the
// FSM can act on the same clk edge that moves sck.
module spi_sck_gen #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_run,
  input  logic             i_sck_en,
  output logic [DIV_W-1:0] o_div_cnt,
  output logic             o_sck,
  output logic             o_rise,
  output logic             o_fall
);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sck;
  logic             w_wrap;

  // Divider wrap: last cycle of the current half-period.
  always_comb begin
    w_wrap = 1'b0;
    if (i_run && (r_div_cnt == DIV_W'(CLK_DIV - 1))) begin
      w_wrap = 1'b1;
    end else begin
      w_wrap = 1'b0;
    end
  end

  assign o_rise    = w_wrap & i_sck_en & ~r_sck;
  assign o_fall    = w_wrap & i_sck_en & r_sck;
  assign o_div_cnt = r_div_cnt;
  assign o_sck     = r_sck;

  // Divider count and sck level; both parked at zero while not running.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_sck     <= 1'b0;
    end else if (!i_run) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_sck     <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_div_cnt <= {DIV_W{1'b0}};
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      if (!i_sck_en) begin
        r_sck <= 1'b0;
      end else if (w_wrap) begin
        r_sck <= ~r_sck;
      end else begin
        r_sck <= r_sck;
      end
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: sends one opcode byte MSB first, then clocks in
// rx_len response bytes and presents each on an rx_valid strobe.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       opcode,
  input  logic [LEN_W-1:0] rx_len,
  output logic             busy,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             done,
  output logic             sck,
  output logic             cs,
  output logic             copi,
  input  logic             cipo
);

  localparam int DIV_W = $clog2(CLK_DIV);

  if (CLK_DIV < MIN_CLK_DIV) begin : g_div_check
    $error("spi_controller: CLK_DIV must be >= 4");
  end

  spi_state_e       r_state;
  logic [2:0]       r_bit_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_in_opc;
  logic [6:0]       r_opc;
  logic [6:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_done;
  logic             r_busy;
  logic             r_cs;
  logic             r_copi;

  logic             w_run;
  logic             w_sck_en;
  logic [DIV_W-1:0] w_div_cnt;
  logic             w_sck;
  logic             w_rise;
  logic             w_fall;
  logic             w_tick;
  logic             w_last;

  // Divider runs whenever a transaction is active; sck toggles only in LOW/HIGH.
  always_comb begin
    w_run    = 1'b0;
    w_sck_en = 1'b0;
    if (r_state != ST_IDLE) begin
      w_run = 1'b1;
    end else begin
      w_run = 1'b0;
    end
    if ((r_state == ST_LOW) || (r_state == ST_HIGH)) begin
      w_sck_en = 1'b1;
    end else begin
      w_sck_en = 1'b0;
    end
  end

  assign w_tick = (w_div_cnt == DIV_W'(CLK_DIV - 1));
  // After a response byte completes r_len has already been decremented,
  // so zero means no further bytes are owed.
  assign w_last = (r_len == {LEN_W{1'b0}});

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_sck_gen (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_run     (w_run),
    .i_sck_en  (w_sck_en),
    .o_div_cnt (w_div_cnt),
    .o_sck     (w_sck),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  // Transaction FSM with registered cs/copi/busy/strobes and receive shifter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_len      <= {LEN_W{1'b0}};
      r_in_opc   <= 1'b0;
      r_opc      <= 7'd0;
      r_shift    <= 7'd0;
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_cs       <= 1'b1;
      r_copi     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_LOW;
            r_busy    <= 1'b1;
            r_cs      <= 1'b0;
            r_copi    <= opcode[7];
            r_opc     <= opcode[6:0];
            r_len     <= rx_len;
            r_bit_cnt <= 3'd0;
            r_in_opc  <= 1'b1;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            r_state <= ST_HIGH;
            r_shift <= {r_shift[5:0], cipo};
            if (!r_in_opc && (r_bit_cnt == 3'd7)) begin
              r_rx_data  <= {r_shift, cipo};
              r_rx_valid <= 1'b1;
              r_len      <= r_len - LEN_W'(1);
            end
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if ((r_bit_cnt == 3'd7) && w_last) begin
              r_state <= ST_HOLD;
              r_copi  <= 1'b0;
            end else begin
              r_state <= ST_LOW;
              if (r_bit_cnt == 3'd7) begin
                r_in_opc <= 1'b0;
                r_copi   <= 1'b0;
              end else if (r_in_opc) begin
                r_copi <= r_opc[6];
                r_opc  <= {r_opc[5:0], 1'b0};
              end else begin
                r_copi <= 1'b0;
              end
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_state <= ST_GAP;
            r_cs    <= 1'b1;
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cs    <= 1'b1;
          r_copi  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign done     = r_done;
  assign sck      = w_sck;
  assign cs       = r_cs;
  assign copi     = r_copi;

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI controller (initiator) for the FPGA's internal test and bring-up paths. It issues one 8-bit opcode, then clocks in a programmable number of response bytes from an SPI peripheral. That peripheral samples SCK, CS and COPI with a 2-flop synchronizer on its own clock and changes CIPO on SCK falling edges. The controller runs in mode 0 (SCK idles low), MSB first, with active-low CS, and presents received bytes on a valid-strobe stream to fabric logic.

## Interface
Parameters:
- CLK_DIV, 4, SCK half-period in clk cycles. Elaboration error if < 4, because the peripheral needs 3 clk cycles from SCK fall to a valid CIPO.
- LEN_W, 16, width of rx_len.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request. Accepted only on a clk edge where busy=0.
- opcode  in  8  command byte, captured on accept.
- rx_len  in  LEN_W  number of response bytes, captured on accept. 0 is legal.
- busy  out  1  high from the cycle after accept up to, but not including, the done cycle.
- rx_data  out  8  last received byte, held between strobes.
- rx_valid  out  1  one-cycle strobe per received byte.
- done  out  1  one-cycle strobe at the end of a transaction.
- sck  out  1  SPI clock.
- cs  out  1  chip select, active low.
- copi  out  1  controller-to-peripheral data.
- cipo  in  1  peripheral-to-controller data.

## Operation
- State machine:
  - IDLE: start accepted, go to LOW.
  - LOW: CLK_DIV cycles, then go to HIGH.
  - HIGH: CLK_DIV cycles. If bits remain, go to LOW; otherwise go to HOLD.
  - HOLD: CLK_DIV cycles with sck=0 and cs=0, then go to GAP.
  - GAP: CLK_DIV cycles with cs=1, then go to IDLE with a done pulse.
- Total bits B = 8·(1+rx_len). The captured rx_len is decremented once per completed response byte. Use a 3-bit bit counter and a CLK_DIV-range divider counter.
- copi:
  - Opcode bits are driven MSB first. Each bit changes only when entering LOW; the first bit is driven in the first LOW cycle.
  - copi=0 during response bytes, HOLD, GAP and IDLE.
- cipo sampling:
  - cipo is captured into a shift register on the clk edge that takes sck 0→1.
  - The 8 samples taken during the opcode byte are discarded.
  - For each response byte, the same edge that captures its 8th bit loads rx_data (MSB first) and asserts rx_valid for one cycle.
- A start received while busy=1 is ignored; it is neither queued nor latched.
- opcode and rx_len are sampled only on accept. Later changes have no effect on the transaction in progress.
- reset_n low at any time, including mid-transaction, immediately forces:
  - cs=1, sck=0, copi=0
  - busy=0, rx_valid=0, done=0, rx_data=0
  - state IDLE, all counters 0.
- No partial byte is ever emitted.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Let T0 be the first cycle after the accept edge. In T0: cs=0, busy=1, copi=opcode[7].
- Bit k (k = 0..B−1):
  - sck rises at T0+(2k+1)·CLK_DIV and falls at T0+(2k+2)·CLK_DIV.
  - The cipo sample for bit k is taken on the rising edge.
- rx_valid for response byte j (j = 0..rx_len−1) is high in cycle T0+(16j+31)·CLK_DIV.
- cs rises at T0+(2B+1)·CLK_DIV.
- done=1 and busy=0 at T0+(2B+2)·CLK_DIV.
- A start in the done cycle is accepted; the next CS-high gap is then CLK_DIV+1 cycles.
- Strobe spacing: consecutive rx_valid pulses are exactly 16·CLK_DIV cycles apart.

## Structure
- Shared package spi_pkg holds:
  - opcode constants: CHIPID_REG=8'h00, DBG8_REG=8'hB8, DBG32_REG=8'hB9, DBG_RAM16=8'hBA, DBG_RAM32=8'hBB
  - CHIPID=8'hAA
  - the controller state enum.
- One sub-module, spi_sck_gen. It takes a run input and generates the divider count, sck, and single-cycle rise/fall event pulses that the main FSM consumes.

## Test plan
- Reset: hold reset_n low, then release with start=0. Required: cs=1, sck=0, copi=0, busy=0, no strobes for 100 cycles.
- CHIPID read: CLK_DIV=4, opcode=0x00, rx_len=1, bench peripheral model answers 0xAA. Required:
  - copi shows 00000000
  - a single rx_valid with rx_data=0xAA at T0+124
  - done at T0+136
  - exactly 16 sck pulses.
- 32-bit read: opcode=0xB9, rx_len=4, model returns 0xDEADBEEF. Required:
  - rx_data sequence 0xDE, 0xAD, 0xBE, 0xEF
  - strobes 64 cycles apart, the first at T0+124
  - done at T0+328.
- Opcode only: opcode=0xA5, rx_len=0. Required:
  - copi bits 1,0,1,0,0,1,0,1 on successive sck rises
  - no rx_valid
  - done at T0+72.
- Handshake: start pulsed mid-transaction is ignored, with only one done. A start asserted in the done cycle begins a new transaction with cs low in the next cycle.
- Reset mid-transaction: assert reset_n low during response byte 2 of a 4-byte read. Required:
  - outputs return to their reset values immediately, with no further rx_valid
  - a following CHIPID read returns 0xAA correctly.
